// File: rtl/frame_dma_sequencer_pkg.sv
// Shared FSM typedefs and helpers for the frame-boundary DMA sequencer.
// The fallback macros below stand in for constants.svh when it is not part of the build.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 8
`endif
`ifndef KEY_NUM
`define KEY_NUM 4
`endif
`ifndef KEY_MEM
`define KEY_MEM 8'h00
`endif

package frame_dma_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    START = 2'd2,
    COPY  = 2'd3
  } frame_seq_state_t;

  typedef enum logic [1:0] {
    SEL_CPU   = 2'd0,
    SEL_BLOCK = 2'd1,
    SEL_BTN   = 2'd2
  } port_sel_t;

  localparam int FRAME_CNT_W = 16;
  localparam int OVR_CNT_W   = 8;

  function automatic logic [OVR_CNT_W-1:0] sat_inc8(input logic [OVR_CNT_W-1:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_dma_sequencer.sv
// Owns the data-memory write port: CPU normally, button DMA for KEY_NUM cycles after vblank.
// Also tracks completed copies and frames whose vblank beat cpu_frame_done.
module frame_dma_sequencer
  import frame_dma_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = `DATA_ADDR_WIDTH,
  parameter int KEY_NUM    = `KEY_NUM
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vblank,
  input  logic                   cpu_frame_done,
  input  logic                   cpu_mem_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_mem_addr,
  input  logic [15:0]            cpu_mem_din,
  input  logic                   btn_mem_we,
  input  logic [ADDR_WIDTH-1:0]  btn_mem_addr,
  input  logic [15:0]            btn_mem_din,
  output logic                   copy_start,
  output logic                   cpu_stall,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [15:0]            mem_din,
  output logic [15:0]            frame_count,
  output logic [7:0]             overrun_count
);

  localparam int CNT_W = $clog2(KEY_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_NUM - 1);

  frame_seq_state_t        state_r;
  frame_seq_state_t        state_nxt_s;
  port_sel_t               sel_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [FRAME_CNT_W-1:0]  frame_count_r;
  logic [OVR_CNT_W-1:0]    overrun_count_r;

  // State register plus copy counter and frame/overrun statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= RUN;
      cnt_r           <= '0;
      frame_count_r   <= 16'd0;
      overrun_count_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        RUN: begin
          if (vblank && !cpu_frame_done) begin
            overrun_count_r <= sat_inc8(overrun_count_r);
          end
        end
        START: cnt_r <= '0;
        COPY: begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            frame_count_r <= frame_count_r + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode; vblank during START/COPY is deliberately dropped.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (vblank) begin
          state_nxt_s = START;
        end else if (cpu_frame_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      IDLE: begin
        if (vblank) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: state_nxt_s = COPY;
      COPY: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = COPY;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    cpu_stall  = 1'b1;
    copy_start = 1'b0;
    sel_s      = SEL_BLOCK;
    case (state_r)
      RUN: begin
        cpu_stall = 1'b0;
        sel_s     = SEL_CPU;
      end
      IDLE:  sel_s = SEL_BLOCK;
      START: begin
        copy_start = 1'b1;
        sel_s      = SEL_BLOCK;
      end
      COPY:  sel_s = SEL_BTN;
      default: begin
        cpu_stall = 1'b0;
        sel_s     = SEL_CPU;
      end
    endcase
  end

  // Write-port mux; the CPU path stays combinational so a write in the vblank cycle lands.
  always_comb begin
    mem_we   = cpu_mem_we;
    mem_addr = cpu_mem_addr;
    mem_din  = cpu_mem_din;
    case (sel_s)
      SEL_CPU: mem_we = cpu_mem_we;
      SEL_BTN: begin
        mem_we   = btn_mem_we;
        mem_addr = btn_mem_addr;
        mem_din  = btn_mem_din;
      end
      SEL_BLOCK: mem_we = 1'b0;
      default:   mem_we = 1'b0;
    endcase
  end

  assign frame_count   = frame_count_r;
  assign overrun_count = overrun_count_r;

endmodule

// File: tb/tb_frame_dma_sequencer.sv
// Directed bench for frame_dma_sequencer with KEY_NUM=4.
module tb_frame_dma_sequencer;

  localparam int AW = 8;
  localparam int KN = 4;

  logic           clk;
  logic           reset_n;
  logic           vblank;
  logic           cpu_frame_done;
  logic           cpu_mem_we;
  logic [AW-1:0]  cpu_mem_addr;
  logic [15:0]    cpu_mem_din;
  logic           btn_mem_we;
  logic [AW-1:0]  btn_mem_addr;
  logic [15:0]    btn_mem_din;
  logic           copy_start;
  logic           cpu_stall;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [15:0]    mem_din;
  logic [15:0]    frame_count;
  logic [7:0]     overrun_count;

  int vec_cnt;
  int err_cnt;
  int cs_seen;
  int exp_fc;
  int exp_oc;

  frame_dma_sequencer #(.ADDR_WIDTH(AW), .KEY_NUM(KN)) dut (
    .clk(clk), .reset_n(reset_n), .vblank(vblank), .cpu_frame_done(cpu_frame_done),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_din(cpu_mem_din),
    .btn_mem_we(btn_mem_we), .btn_mem_addr(btn_mem_addr), .btn_mem_din(btn_mem_din),
    .copy_start(copy_start), .cpu_stall(cpu_stall), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after vblank was accepted: checks START, the KEY_NUM COPY cycles and return to RUN.
  task automatic do_copy(input bit extra_vb, input bit full);
    cpu_mem_we = 1'b1; cpu_mem_addr = 8'h11; cpu_mem_din = 16'hC0DE;
    #1;
    if (copy_start) cs_seen++;
    if (full) begin
      chk("start_copy_start", 32'(copy_start), 32'd1);
      chk("start_stall", 32'(cpu_stall), 32'd1);
      chk("start_we_blocked", 32'(mem_we), 32'd0);
      chk("start_addr_cpu", 32'(mem_addr), 32'h11);
    end
    for (int k = 0; k < KN; k++) begin
      step();
      vblank = 1'b0;
      btn_mem_we   = k[0];
      btn_mem_addr = 8'(8'h40 + k);
      btn_mem_din  = 16'(16'hB000 + k);
      #1;
      if (copy_start) cs_seen++;
      if (full) begin
        chk("copy_stall", 32'(cpu_stall), 32'd1);
        chk("copy_we", 32'(mem_we), 32'(k[0]));
        chk("copy_addr", 32'(mem_addr), 32'(8'h40 + k));
        chk("copy_din", 32'(mem_din), 32'(16'hB000 + k));
      end
      if (k == KN - 1) chk("copy_fc_old", 32'(frame_count), 32'(exp_fc));
      if (extra_vb && k == 1) vblank = 1'b1;
    end
    step();
    vblank = 1'b0;
    exp_fc = (exp_fc + 1) & 16'hFFFF;
    chk("run_stall", 32'(cpu_stall), 32'd0);
    chk("run_copy_start", 32'(copy_start), 32'd0);
    chk("run_we_cpu", 32'(mem_we), 32'd1);
    chk("run_fc", 32'(frame_count), 32'(exp_fc));
    chk("run_oc", 32'(overrun_count), 32'(exp_oc));
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0; cs_seen = 0; exp_fc = 0; exp_oc = 0;
    reset_n = 1'b0; vblank = 1'b0; cpu_frame_done = 1'b0;
    cpu_mem_we = 1'b0; cpu_mem_addr = 8'h00; cpu_mem_din = 16'h0000;
    btn_mem_we = 1'b0; btn_mem_addr = 8'h00; btn_mem_din = 16'h0000;
    repeat (2) step();
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_copy_start", 32'(copy_start), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_oc", 32'(overrun_count), 32'd0);
    reset_n = 1'b1;
    repeat (3) step();
    cpu_mem_we = 1'b1; cpu_mem_addr = 8'h23; cpu_mem_din = 16'h1234;
    #1;
    chk("idle_we_hi", 32'(mem_we), 32'd1);
    chk("idle_addr", 32'(mem_addr), 32'h23);
    chk("idle_din", 32'(mem_din), 32'h1234);
    cpu_mem_we = 1'b0;
    #1;
    chk("idle_we_lo", 32'(mem_we), 32'd0);
    chk("idle_stall", 32'(cpu_stall), 32'd0);

    // frame_done then vblank later: no overrun
    cpu_frame_done = 1'b1;
    step();
    cpu_frame_done = 1'b0;
    cpu_mem_we = 1'b1;
    #1;
    chk("fd_stall", 32'(cpu_stall), 32'd1);
    chk("fd_we_blocked", 32'(mem_we), 32'd0);
    repeat (9) step();
    chk("fd_still_idle", 32'(cpu_stall), 32'd1);
    chk("fd_no_start", 32'(copy_start), 32'd0);
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    do_copy(1'b0, 1'b1);

    // vblank together with frame_done: no overrun
    repeat (2) step();
    vblank = 1'b1; cpu_frame_done = 1'b1;
    step();
    vblank = 1'b0; cpu_frame_done = 1'b0;
    do_copy(1'b0, 1'b1);

    // extra vblank during COPY is ignored
    cs_seen = 0;
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    exp_oc = exp_oc + 1;
    do_copy(1'b1, 1'b1);
    step();
    chk("extra_vb_stay_run", 32'(cpu_stall), 32'd0);
    chk("extra_vb_one_start", 32'(cs_seen), 32'd1);
    chk("extra_vb_fc", 32'(frame_count), 32'(exp_fc));

    // CPU write in the vblank cycle still reaches memory
    cpu_mem_we = 1'b1; cpu_mem_addr = 8'h5A; vblank = 1'b1;
    #1;
    chk("vb_cycle_we", 32'(mem_we), 32'd1);
    chk("vb_cycle_addr", 32'(mem_addr), 32'h5A);
    step();
    vblank = 1'b0;
    exp_oc = exp_oc + 1;
    do_copy(1'b0, 1'b1);

    // repeated overruns saturate at 255
    for (int i = 0; i < 300; i++) begin
      vblank = 1'b1;
      step();
      vblank = 1'b0;
      if (exp_oc < 255) exp_oc = exp_oc + 1;
      do_copy(1'b0, 1'b0);
    end
    chk("oc_saturated", 32'(overrun_count), 32'd255);

    // async reset in COPY cycle 2
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
    step();
    chk("pre_rst_stall", 32'(cpu_stall), 32'd1);
    btn_mem_we = 1'b1; cpu_mem_we = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(cpu_stall), 32'd0);
    chk("midrst_copy_start", 32'(copy_start), 32'd0);
    chk("midrst_fc", 32'(frame_count), 32'd0);
    chk("midrst_oc", 32'(overrun_count), 32'd0);
    chk("midrst_we_lo", 32'(mem_we), 32'd0);
    cpu_mem_we = 1'b1;
    #1;
    chk("midrst_we_hi", 32'(mem_we), 32'd1);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_stall", 32'(cpu_stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
